// File: rtl/sramlike_arbiter.sv
// Two-to-one arbiter sharing one sram-like memory port between the instruction-fetch
// and data masters; one outstanding transaction, tracked through address and data phases.
module sramlike_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,

   output logic        busy
);

   localparam int NUM_MASTERS = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t state_reg, state_next;
   logic   owner_reg, owner_next;
   logic   last_reg,  last_next;
   logic   sel;
   logic   grant;

   // Master 0 is instruction fetch, master 1 is data access.
   logic [NUM_MASTERS-1:0]       req_vec;
   logic [NUM_MASTERS-1:0]       wr_vec;
   logic [NUM_MASTERS-1:0][1:0]  size_vec;
   logic [NUM_MASTERS-1:0][31:0] addr_vec;
   logic [NUM_MASTERS-1:0][31:0] wdata_vec;
   logic [NUM_MASTERS-1:0]       addr_ok_vec;
   logic [NUM_MASTERS-1:0]       data_ok_vec;

   assign req_vec   = {data_req,   inst_req};
   assign wr_vec    = {data_wr,    inst_wr};
   assign size_vec  = {data_size,  inst_size};
   assign addr_vec  = {data_addr,  inst_addr};
   assign wdata_vec = {data_wdata, inst_wdata};

   assign inst_addr_ok = addr_ok_vec[0];
   assign data_addr_ok = addr_ok_vec[1];
   assign inst_data_ok = data_ok_vec[0];
   assign data_data_ok = data_ok_vec[1];

   // Read data is broadcast; each master qualifies it with its own data_ok.
   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

   assign busy = (state_reg != ST_IDLE);

   always_comb begin
      sel = req_vec[1];
      if (req_vec == 2'b11) begin
         sel = RR_EN ? ~last_reg : 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= ST_IDLE;
         owner_reg <= 1'b0;
         last_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         last_reg  <= last_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      last_next   = last_reg;
      grant       = owner_reg;
      mem_req     = 1'b0;
      addr_ok_vec = '0;
      data_ok_vec = '0;

      case (state_reg)
         ST_IDLE: begin
            grant = sel;
            if (|req_vec) begin
               mem_req    = 1'b1;
               owner_next = sel;
               if (mem_addr_ok) begin
                  addr_ok_vec[sel] = 1'b1;
                  last_next        = sel;
                  state_next       = ST_DATA;
               end else begin
                  state_next = ST_ADDR;
               end
            end
         end

         ST_ADDR: begin
            // Grant is locked; an owner dropping req abandons the transfer silently.
            if (req_vec[owner_reg]) begin
               mem_req = 1'b1;
               if (mem_addr_ok) begin
                  addr_ok_vec[owner_reg] = 1'b1;
                  last_next              = owner_reg;
                  state_next             = ST_DATA;
               end
            end else begin
               state_next = ST_IDLE;
            end
         end

         ST_DATA: begin
            if (mem_data_ok) begin
               data_ok_vec[owner_reg] = 1'b1;
               state_next             = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Request attributes are forced to zero whenever no request is presented.
   always_comb begin
      mem_wr    = 1'b0;
      mem_size  = 2'd0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (mem_req) begin
         mem_wr    = wr_vec[grant];
         mem_size  = size_vec[grant];
         mem_addr  = addr_vec[grant];
         mem_wdata = wdata_vec[grant];
      end
   end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model, run on a round-robin and a fixed-priority instance.
module tb_sramlike_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   logic        rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok;
   logic [31:0] rr_inst_rdata, rr_data_rdata;
   logic        rr_mem_req, rr_mem_wr, rr_busy;
   logic [1:0]  rr_mem_size;
   logic [31:0] rr_mem_addr, rr_mem_wdata;

   logic        fx_inst_addr_ok, fx_inst_data_ok, fx_data_addr_ok, fx_data_data_ok;
   logic [31:0] fx_inst_rdata, fx_data_rdata;
   logic        fx_mem_req, fx_mem_wr, fx_busy;
   logic [1:0]  fx_mem_size;
   logic [31:0] fx_mem_addr, fx_mem_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sramlike_arbiter #(.RR_EN(1'b1)) u_rr (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(rr_inst_addr_ok), .inst_data_ok(rr_inst_data_ok),
      .inst_rdata(rr_inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(rr_data_addr_ok), .data_data_ok(rr_data_data_ok),
      .data_rdata(rr_data_rdata),
      .mem_req(rr_mem_req), .mem_wr(rr_mem_wr), .mem_size(rr_mem_size), .mem_addr(rr_mem_addr),
      .mem_wdata(rr_mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata), .busy(rr_busy)
   );

   sramlike_arbiter #(.RR_EN(1'b0)) u_fx (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(fx_inst_addr_ok), .inst_data_ok(fx_inst_data_ok),
      .inst_rdata(fx_inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(fx_data_addr_ok), .data_data_ok(fx_data_data_ok),
      .data_rdata(fx_data_rdata),
      .mem_req(fx_mem_req), .mem_wr(fx_mem_wr), .mem_size(fx_mem_size), .mem_addr(fx_mem_addr),
      .mem_wdata(fx_mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata), .busy(fx_busy)
   );

   typedef struct packed {
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_t;

   typedef struct packed {
      logic iaok;
      logic daok;
      logic idok;
      logic ddok;
      logic busy;
   } ack_t;

   // holder: -1 = port free, 0 = inst, 1 = data; awaiting = address accepted, data pending
   typedef struct {
      int holder;
      bit awaiting;
      bit last;
   } mdl_t;

   mem_t act_mem [2];
   ack_t act_ack [2];
   assign act_mem[0] = {rr_mem_req, rr_mem_wr, rr_mem_size, rr_mem_addr, rr_mem_wdata};
   assign act_mem[1] = {fx_mem_req, fx_mem_wr, fx_mem_size, fx_mem_addr, fx_mem_wdata};
   assign act_ack[0] = {rr_inst_addr_ok, rr_data_addr_ok, rr_inst_data_ok, rr_data_data_ok, rr_busy};
   assign act_ack[1] = {fx_inst_addr_ok, fx_data_addr_ok, fx_inst_data_ok, fx_data_data_ok, fx_busy};

   function automatic void model_eval(input bit rr, input mdl_t s,
                                      output mem_t em, output ack_t ea, output mdl_t n);
      int       who;
      bit [1:0] rq;
      rq = {data_req, inst_req};
      n  = s;
      em = '0;
      ea = '0;
      who = s.holder;
      ea.busy = (s.holder >= 0);
      if (s.awaiting) begin
         if (mem_data_ok) begin
            if (who == 0) ea.idok = 1'b1;
            else          ea.ddok = 1'b1;
            n.holder   = -1;
            n.awaiting = 1'b0;
         end
      end else begin
         if (who < 0) begin
            if (rq == 2'b11)  who = rr ? (s.last ? 0 : 1) : 1;
            else if (rq[1])   who = 1;
            else if (rq[0])   who = 0;
         end
         if (who >= 0 && rq[who]) begin
            em.req   = 1'b1;
            em.wr    = (who == 1) ? data_wr    : inst_wr;
            em.size  = (who == 1) ? data_size  : inst_size;
            em.addr  = (who == 1) ? data_addr  : inst_addr;
            em.wdata = (who == 1) ? data_wdata : inst_wdata;
            n.holder = who;
            if (mem_addr_ok) begin
               if (who == 0) ea.iaok = 1'b1;
               else          ea.daok = 1'b1;
               n.awaiting = 1'b1;
               n.last     = (who == 1);
            end
         end else begin
            n.holder = -1;
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      resetn = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if ({act_mem[0], act_ack[0], act_mem[1], act_ack[1]} !== '0) begin
         errors++;
         $display("FAIL reset_in_reset: got %h required 0", {act_mem[0], act_ack[0], act_mem[1], act_ack[1]});
      end
      step();
      resetn = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if ({act_mem[0], act_ack[0], act_mem[1], act_ack[1]} !== '0) begin
         errors++;
         $display("FAIL reset_after: got %h required 0", {act_mem[0], act_ack[0], act_mem[1], act_ack[1]});
      end
      $display("test_reset done");
   endtask

   task automatic test_single_inst_read();
      do_reset();
      step();
      inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0000;
      mem_addr_ok = 1;
      @(negedge clk);
      checks++;
      if ({rr_mem_req, rr_mem_addr, rr_inst_addr_ok, rr_busy} !== {1'b1, 32'hBFC0_0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL inst_read_c0: got req=%b addr=%h aok=%b busy=%b required 1 bfc00000 1 0",
                  rr_mem_req, rr_mem_addr, rr_inst_addr_ok, rr_busy);
      end
      step();
      inst_req = 0; mem_addr_ok = 0;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) begin
            mem_data_ok = 1;
            mem_rdata   = 32'h3C08_BFAF;
         end
         @(negedge clk);
         checks++;
         if ({rr_busy, rr_mem_req, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok, rr_inst_addr_ok}
             !== {1'b1, 1'b0, (c == 3), 3'b000}) begin
            errors++;
            $display("FAIL inst_read_c%0d: got busy=%b req=%b idok=%b daok=%b ddok=%b iaok=%b required 1 0 %0d 0 0 0",
                     c, rr_busy, rr_mem_req, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok,
                     rr_inst_addr_ok, (c == 3));
         end
         if (c == 3) begin
            checks++;
            if (rr_inst_rdata !== 32'h3C08_BFAF) begin
               errors++;
               $display("FAIL inst_read_rdata: got %h required 3c08bfaf", rr_inst_rdata);
            end
         end
         step();
      end
      mem_data_ok = 0;
      @(negedge clk);
      checks++;
      if (rr_busy !== 1'b0) begin
         errors++;
         $display("FAIL inst_read_idle: got busy=%b required 0", rr_busy);
      end
      $display("test_single_inst_read done");
   endtask

   task automatic test_conflict();
      bit exp_data;
      do_reset();
      inst_req = 1; inst_addr = 32'h0000_1000;
      data_req = 1; data_addr = 32'h0000_2000;
      mem_addr_ok = 1; mem_data_ok = 1;
      for (int k = 0; k < 8; k++) begin
         exp_data = ((k / 2) % 2 == 0);
         @(negedge clk);
         checks++;
         if (k % 2 == 0) begin
            if ({rr_mem_req, rr_data_addr_ok, rr_inst_addr_ok, rr_inst_data_ok, rr_data_data_ok}
                !== {1'b1, exp_data, !exp_data, 2'b00}) begin
               errors++;
               $display("FAIL conflict_rr_grant%0d: got req=%b daok=%b iaok=%b required 1 %b %b",
                        k / 2, rr_mem_req, rr_data_addr_ok, rr_inst_addr_ok, exp_data, !exp_data);
            end
         end else begin
            if ({rr_mem_req, rr_data_data_ok, rr_inst_data_ok, rr_inst_addr_ok, rr_data_addr_ok}
                !== {1'b0, exp_data, !exp_data, 2'b00}) begin
               errors++;
               $display("FAIL conflict_rr_done%0d: got req=%b ddok=%b idok=%b required 0 %b %b",
                        k / 2, rr_mem_req, rr_data_data_ok, rr_inst_data_ok, exp_data, !exp_data);
            end
         end
         checks++;
         if (fx_inst_addr_ok !== 1'b0 || fx_data_addr_ok !== (k % 2 == 0)) begin
            errors++;
            $display("FAIL conflict_fixed%0d: got iaok=%b daok=%b required 0 %0d",
                     k, fx_inst_addr_ok, fx_data_addr_ok, (k % 2 == 0));
         end
         step();
      end
      clear_inputs();
      $display("test_conflict done");
   endtask

   task automatic test_addr_stall();
      do_reset();
      data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            inst_req = 1; inst_addr = 32'hBFC0_0010;
         end
         mem_addr_ok = (c == 4);
         @(negedge clk);
         checks++;
         if ({rr_mem_req, rr_mem_wr, rr_mem_addr, rr_mem_wdata, rr_inst_addr_ok, rr_data_addr_ok}
             !== {2'b11, 32'h8000_1000, 32'hDEAD_BEEF, 1'b0, (c == 4)}) begin
            errors++;
            $display("FAIL stall_c%0d: got req=%b wr=%b addr=%h wdata=%h iaok=%b daok=%b required 1 1 80001000 deadbeef 0 %0d",
                     c, rr_mem_req, rr_mem_wr, rr_mem_addr, rr_mem_wdata, rr_inst_addr_ok,
                     rr_data_addr_ok, (c == 4));
         end
         step();
      end
      data_req = 0; mem_addr_ok = 1;
      for (int c = 5; c < 7; c++) begin
         mem_data_ok = (c == 6);
         @(negedge clk);
         checks++;
         if ({rr_mem_req, rr_inst_addr_ok, rr_data_data_ok} !== {2'b00, (c == 6)}) begin
            errors++;
            $display("FAIL stall_data_c%0d: got req=%b iaok=%b ddok=%b required 0 0 %0d",
                     c, rr_mem_req, rr_inst_addr_ok, rr_data_data_ok, (c == 6));
         end
         step();
      end
      mem_data_ok = 0;
      @(negedge clk);
      checks++;
      if ({rr_mem_req, rr_mem_addr, rr_inst_addr_ok} !== {1'b1, 32'hBFC0_0010, 1'b1}) begin
         errors++;
         $display("FAIL stall_inst_grant: got req=%b addr=%h iaok=%b required 1 bfc00010 1",
                  rr_mem_req, rr_mem_addr, rr_inst_addr_ok);
      end
      step();
      clear_inputs();
      $display("test_addr_stall done");
   endtask

   task automatic test_stray();
      do_reset();
      mem_data_ok = 1;
      @(negedge clk);
      checks++;
      if (act_ack[0] !== '0) begin
         errors++;
         $display("FAIL stray_idle: got acks=%b required 00000", act_ack[0]);
      end
      step();
      mem_data_ok = 0; inst_req = 1; inst_addr = 32'h0000_0040; mem_addr_ok = 1;
      step();
      inst_req = 0; data_req = 1; data_addr = 32'h0000_0080;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (act_ack[0] !== 5'b00001 || rr_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_data_c%0d: got acks=%b req=%b required 00001 0", c, act_ack[0], rr_mem_req);
         end
         step();
      end
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      @(negedge clk);
      checks++;
      if (act_ack[0] !== 5'b00101) begin
         errors++;
         $display("FAIL stray_complete: got acks=%b required 00101", act_ack[0]);
      end
      step();
      clear_inputs();
      $display("test_stray done");
   endtask

   task automatic test_reset_in_data();
      do_reset();
      data_req = 1; data_addr = 32'h0000_0100; mem_addr_ok = 1;
      step();
      data_req = 0; mem_addr_ok = 0;
      resetn = 0; mem_data_ok = 1;
      @(negedge clk);
      checks++;
      if ({rr_data_data_ok, rr_inst_data_ok, rr_busy} !== 3'b000) begin
         errors++;
         $display("FAIL rst_data: got ddok=%b idok=%b busy=%b required 0 0 0",
                  rr_data_data_ok, rr_inst_data_ok, rr_busy);
      end
      step();
      resetn = 1; mem_data_ok = 0;
      inst_req = 1; data_req = 1; inst_addr = 32'h0000_0200; mem_addr_ok = 1;
      @(negedge clk);
      checks++;
      if ({rr_data_addr_ok, rr_inst_addr_ok, rr_mem_addr} !== {2'b10, 32'h0000_0100}) begin
         errors++;
         $display("FAIL rst_next_grant: got daok=%b iaok=%b addr=%h required 1 0 00000100",
                  rr_data_addr_ok, rr_inst_addr_ok, rr_mem_addr);
      end
      step();
      clear_inputs();
      $display("test_reset_in_data done");
   endtask

   task automatic test_random();
      mdl_t mdl [2];
      mdl_t nx  [2];
      mem_t em  [2];
      ack_t ea  [2];
      do_reset();
      for (int d = 0; d < 2; d++) begin
         mdl[d] = '{holder: -1, awaiting: 1'b0, last: 1'b0};
         nx[d]  = mdl[d];
      end
      for (int i = 0; i < 600; i++) begin
         inst_req    = ($urandom_range(0, 3) != 0);
         data_req    = ($urandom_range(0, 2) != 0);
         inst_wr     = $urandom_range(0, 1);
         data_wr     = $urandom_range(0, 1);
         inst_size   = 2'($urandom_range(0, 2));
         data_size   = 2'($urandom_range(0, 2));
         inst_addr   = $urandom;
         data_addr   = $urandom;
         inst_wdata  = $urandom;
         data_wdata  = $urandom;
         mem_addr_ok = $urandom_range(0, 1);
         mem_data_ok = ($urandom_range(0, 2) == 0);
         mem_rdata   = $urandom;
         for (int d = 0; d < 2; d++) begin
            model_eval(d == 0, mdl[d], em[d], ea[d], nx[d]);
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (act_mem[d] !== em[d]) begin
               errors++;
               $display("FAIL rand_mem dut%0d cyc%0d: got %h required %h", d, i, act_mem[d], em[d]);
            end
            checks++;
            if (act_ack[d] !== ea[d]) begin
               errors++;
               $display("FAIL rand_ack dut%0d cyc%0d: got %b required %b", d, i, act_ack[d], ea[d]);
            end
         end
         checks++;
         if ({rr_inst_rdata, rr_data_rdata, fx_inst_rdata, fx_data_rdata} !== {4{mem_rdata}}) begin
            errors++;
            $display("FAIL rand_rdata cyc%0d: got %h %h required %h", i, rr_inst_rdata, rr_data_rdata, mem_rdata);
         end
         step();
         mdl = nx;
      end
      clear_inputs();
      $display("test_random done");
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_inst_read();
      test_conflict();
      test_addr_stall();
      test_stray();
      test_reset_in_data();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
